collision_monitor: RTL and testbench

Game-state monitor downstream of the four ghost controllers and the player controller. On every game tick it compares the player position against all four ghost positions and detects sprite overlap. It manages the life counter and drives a freeze interval after a hit. It also issues respawn and game-over signals back to the movers and the display.

---
 rtl/collision_monitor_pkg.sv | 22 ++
 rtl/collision_monitor_overlap.sv | 24 ++
 rtl/collision_monitor.sv | 139 +++++++++++++
 tb/tb_collision_monitor.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_monitor_pkg.sv
// Shared constants, FSM state type and helpers for the player/ghost collision monitor.
package collision_monitor_pkg;

  localparam int TILE_SIZE  = 16;
  localparam int WIDTH_LOG2 = 10;
  localparam int GHOST_NUM  = 4;

  typedef enum logic [1:0] {
    CM_PLAY   = 2'd0,
    CM_FREEZE = 2'd1,
    CM_OVER   = 2'd2
  } cm_state_e;

  // Index of the lowest-numbered set bit; 0 when the vector is empty.
  function automatic logic [1:0] lowest_set(input logic [GHOST_NUM-1:0] v);
    lowest_set = 2'd0;
    for (int i = GHOST_NUM - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 2'(i);
    end
  endfunction

endpackage

// File: rtl/collision_monitor_overlap.sv
// Combinational sprite overlap test: unsigned |dx| and |dy| (no wrap) both below HIT_DIST.
module sprite_overlap #(
  parameter int W        = 10,
  parameter int HIT_DIST = 16
) (
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
  input  logic [W-1:0] bx,
  input  logic [W-1:0] by,
  output logic         match
);

  localparam logic [W:0] DIST = (W+1)'(HIT_DIST);

  logic [W-1:0] dx;
  logic [W-1:0] dy;

  // Larger minus smaller keeps the distance honest across the screen edge.
  assign dx = (ax >= bx) ? (ax - bx) : (bx - ax);
  assign dy = (ay >= by) ? (ay - by) : (by - ay);

  assign match = ({1'b0, dx} < DIST) && ({1'b0, dy} < DIST);

endmodule

// File: rtl/collision_monitor.sv
// Game-state monitor: samples positions on tick, detects player/ghost overlap,
// manages lives, the post-hit freeze interval, respawn and game over.
module collision_monitor
  import collision_monitor_pkg::*;
#(
  parameter int LIVES         = 3,
  parameter int HIT_DIST      = TILE_SIZE,
  parameter int FREEZE_FRAMES = 60
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tick,
  input  logic                            restart,
  input  logic [WIDTH_LOG2-1:0]           player_x,
  input  logic [WIDTH_LOG2-1:0]           player_y,
  input  logic [GHOST_NUM*WIDTH_LOG2-1:0] ghost_x,
  input  logic [GHOST_NUM*WIDTH_LOG2-1:0] ghost_y,
  output logic                            freeze,
  output logic                            hit,
  output logic [1:0]                      hit_ghost,
  output logic                            respawn,
  output logic [1:0]                      lives,
  output logic                            game_over,
  output cm_state_e                       state_dbg
);

  localparam int         CW         = $clog2(FREEZE_FRAMES + 1);
  localparam logic [CW-1:0] FRZ_INIT = CW'(FREEZE_FRAMES);
  localparam logic [CW-1:0] FRZ_LAST = CW'(1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  cm_state_e                       state_q;
  logic [1:0]                      lives_q;
  logic [CW-1:0]                   frz_cnt_q;
  logic                            freeze_q;
  logic                            hit_q;
  logic [1:0]                      hit_ghost_q;
  logic                            respawn_q;
  logic                            over_q;

  logic                            s1_valid_q;
  logic [WIDTH_LOG2-1:0]           snap_px_q;
  logic [WIDTH_LOG2-1:0]           snap_py_q;
  logic [GHOST_NUM*WIDTH_LOG2-1:0] snap_gx_q;
  logic [GHOST_NUM*WIDTH_LOG2-1:0] snap_gy_q;

  logic [GHOST_NUM-1:0]            match_w;

  for (genvar g = 0; g < GHOST_NUM; g++) begin : g_ghost
    sprite_overlap #(
      .W        (WIDTH_LOG2),
      .HIT_DIST (HIT_DIST)
    ) u_overlap (
      .ax    (snap_px_q),
      .ay    (snap_py_q),
      .bx    (snap_gx_q[g*WIDTH_LOG2 +: WIDTH_LOG2]),
      .by    (snap_gy_q[g*WIDTH_LOG2 +: WIDTH_LOG2]),
      .match (match_w[g])
    );
  end

  // The overlap result is consumed on the same edge that registers it, so
  // hit/lives/freeze appear two cycles after the sampling tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CM_PLAY;
      lives_q     <= LIVES_INIT;
      frz_cnt_q   <= '0;
      freeze_q    <= 1'b0;
      hit_q       <= 1'b0;
      hit_ghost_q <= 2'd0;
      respawn_q   <= 1'b0;
      over_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      snap_px_q   <= '0;
      snap_py_q   <= '0;
      snap_gx_q   <= '0;
      snap_gy_q   <= '0;
    end else begin
      hit_q      <= 1'b0;
      respawn_q  <= 1'b0;
      s1_valid_q <= tick && (state_q == CM_PLAY);
      if (tick && (state_q == CM_PLAY)) begin
        snap_px_q <= player_x;
        snap_py_q <= player_y;
        snap_gx_q <= ghost_x;
        snap_gy_q <= ghost_y;
      end

      case (state_q)
        CM_PLAY: begin
          if (s1_valid_q && (|match_w)) begin
            hit_q       <= 1'b1;
            hit_ghost_q <= lowest_set(match_w);
            freeze_q    <= 1'b1;
            if (lives_q == 2'd1) begin
              lives_q <= 2'd0;
              over_q  <= 1'b1;
              state_q <= CM_OVER;
            end else begin
              lives_q   <= lives_q - 2'd1;
              frz_cnt_q <= FRZ_INIT;
              state_q   <= CM_FREEZE;
            end
          end
        end
        CM_FREEZE: begin
          if (tick) begin
            frz_cnt_q <= frz_cnt_q - FRZ_LAST;
            if (frz_cnt_q == FRZ_LAST) begin
              respawn_q <= 1'b1;
              freeze_q  <= 1'b0;
              state_q   <= CM_PLAY;
            end
          end
        end
        CM_OVER: begin
          if (restart) begin
            lives_q   <= LIVES_INIT;
            respawn_q <= 1'b1;
            freeze_q  <= 1'b0;
            over_q    <= 1'b0;
            state_q   <= CM_PLAY;
          end
        end
        default: state_q <= CM_PLAY;
      endcase
    end
  end

  assign freeze    = freeze_q;
  assign hit       = hit_q;
  assign hit_ghost = hit_ghost_q;
  assign respawn   = respawn_q;
  assign lives     = lives_q;
  assign game_over = over_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_collision_monitor.sv
// Directed and randomized bench for collision_monitor against a behavioural game model.
module tb_collision_monitor;
  import collision_monitor_pkg::*;

  localparam int W   = WIDTH_LOG2;
  localparam int LV  = 3;
  localparam int HD  = 16;
  localparam int FF  = 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 tick = 1'b0;
  logic                 restart = 1'b0;
  logic [W-1:0]         player_x = '0;
  logic [W-1:0]         player_y = '0;
  logic [4*W-1:0]       ghost_x = '0;
  logic [4*W-1:0]       ghost_y = '0;
  logic                 freeze;
  logic                 hit;
  logic [1:0]           hit_ghost;
  logic                 respawn;
  logic [1:0]           lives;
  logic                 game_over;
  cm_state_e            state_dbg;

  int checks = 0;
  int errors = 0;

  collision_monitor #(
    .LIVES         (LV),
    .HIT_DIST      (HD),
    .FREEZE_FRAMES (FF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .restart   (restart),
    .player_x  (player_x),
    .player_y  (player_y),
    .ghost_x   (ghost_x),
    .ghost_y   (ghost_y),
    .freeze    (freeze),
    .hit       (hit),
    .hit_ghost (hit_ghost),
    .respawn   (respawn),
    .lives     (lives),
    .game_over (game_over),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Behavioural game model: flags for "frozen" and "over", tick countdown,
  // and a scoreboard queue of sampled results {overlap, ghost index}.
  bit         m_frozen = 1'b0;
  bit         m_over   = 1'b0;
  int         m_lives  = LV;
  int         m_left   = 0;
  int         m_ghost  = 0;
  bit         m_hit    = 1'b0;
  bit         m_resp   = 1'b0;
  logic [2:0] exp_q[$];

  function automatic logic [2:0] first_overlap();
    int dx;
    int dy;
    for (int g = 0; g < 4; g++) begin
      dx = int'(player_x) - int'(ghost_x[g*W +: W]);
      dy = int'(player_y) - int'(ghost_y[g*W +: W]);
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      if (dx < HD && dy < HD) return {1'b1, 2'(g)};
    end
    return 3'b000;
  endfunction

  task automatic model_step();
    bit         was_play;
    bit         was_frozen;
    bit         was_over;
    logic [2:0] r;
    m_hit  = 1'b0;
    m_resp = 1'b0;
    if (reset) begin
      m_frozen = 1'b0;
      m_over   = 1'b0;
      m_lives  = LV;
      m_left   = 0;
      m_ghost  = 0;
      exp_q.delete();
      return;
    end
    was_play   = !m_frozen && !m_over;
    was_frozen = m_frozen;
    was_over   = m_over;
    r = 3'b000;
    if (exp_q.size() > 0) r = exp_q.pop_front();
    if (was_play && r[2]) begin
      m_hit   = 1'b1;
      m_ghost = int'(r[1:0]);
      if (m_lives == 1) begin
        m_lives = 0;
        m_over  = 1'b1;
      end else begin
        m_lives  = m_lives - 1;
        m_frozen = 1'b1;
        m_left   = FF;
      end
    end
    if (was_frozen && tick) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_frozen = 1'b0;
        m_resp   = 1'b1;
      end
    end
    if (was_over && restart) begin
      m_over  = 1'b0;
      m_lives = LV;
      m_resp  = 1'b1;
    end
    if (was_play && tick) exp_q.push_back(first_overlap());
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    check("hit",       32'(hit),       32'(m_hit));
    check("hit_ghost", 32'(hit_ghost), 32'(m_ghost));
    check("respawn",   32'(respawn),   32'(m_resp));
    check("lives",     32'(lives),     32'(m_lives));
    check("freeze",    32'(freeze),    32'(m_frozen || m_over));
    check("game_over", 32'(game_over), 32'(m_over));
  endtask

  // Driver tasks: inputs change at the falling edge, outputs checked there too.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic tick_step();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic set_ghost(input int i, input int x, input int y);
    ghost_x[i*W +: W] = W'(x);
    ghost_y[i*W +: W] = W'(y);
  endtask

  task automatic scene_far();
    player_x = W'(100);
    player_y = W'(100);
    set_ghost(0, 400, 300);
    set_ghost(1, 200, 200);
    set_ghost(2, 0, 0);
    set_ghost(3, 600, 400);
  endtask

  task automatic freeze_out();
    for (int k = 0; k < FF; k++) begin
      tick_step();
      check("frz_nohit", 32'(hit), 32'd0);
      if (k == FF - 1) begin
        check("frz_respawn", 32'(respawn), 32'd1);
        check("frz_freeze_low", 32'(freeze), 32'd0);
      end else begin
        check("frz_freeze_high", 32'(freeze), 32'd1);
        step();
      end
    end
    step();
    check("respawn_pulse_end", 32'(respawn), 32'd0);
  endtask

  function automatic int near(input int base);
    int off;
    int v;
    case ($urandom_range(0, 4))
      0: off = -16;
      1: off = -15;
      2: off = 15;
      3: off = 16;
      default: off = int'($urandom_range(0, 40)) - 20;
    endcase
    v = base + off;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  initial begin
    int px;
    int py;
    // Reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_freeze", 32'(freeze), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);

    // No overlap anywhere
    scene_far();
    tick_step();
    step();
    step();
    check("far_hit", 32'(hit), 32'd0);
    check("far_lives", 32'(lives), 32'd3);

    // Two ghosts overlapping: lowest index wins, one life lost
    set_ghost(2, 115, 90);
    set_ghost(3, 100, 100);
    tick_step();
    step();
    check("hit1", 32'(hit), 32'd1);
    check("hit1_ghost", 32'(hit_ghost), 32'd2);
    check("hit1_lives", 32'(lives), 32'd2);
    check("hit1_freeze", 32'(freeze), 32'd1);
    step();
    check("hit1_pulse", 32'(hit), 32'd0);
    freeze_out();

    // dx = 15 hits
    scene_far();
    set_ghost(0, 115, 100);
    tick_step();
    step();
    check("dx15_hit", 32'(hit), 32'd1);
    check("dx15_ghost", 32'(hit_ghost), 32'd0);
    check("dx15_lives", 32'(lives), 32'd1);
    freeze_out();

    // dx = 16 does not hit
    scene_far();
    set_ghost(1, 116, 100);
    tick_step();
    step();
    check("dx16_nohit", 32'(hit), 32'd0);
    step();

    // No wrap-around at the screen edge
    player_x = W'(0);
    set_ghost(0, 700, 100);
    set_ghost(2, 1020, 100);
    tick_step();
    step();
    check("nowrap", 32'(hit), 32'd0);
    step();

    // Final life: game over
    scene_far();
    set_ghost(3, 100, 100);
    tick_step();
    step();
    check("last_hit", 32'(hit), 32'd1);
    check("last_ghost", 32'(hit_ghost), 32'd3);
    check("over_lives", 32'(lives), 32'd0);
    check("over_flag", 32'(game_over), 32'd1);
    check("over_freeze", 32'(freeze), 32'd1);
    tick_step();
    step();
    step();
    check("over_nohit", 32'(hit), 32'd0);

    // Restart coinciding with tick: restart wins, nothing sampled
    restart = 1'b1;
    tick = 1'b1;
    step();
    restart = 1'b0;
    tick = 1'b0;
    check("restart_lives", 32'(lives), 32'd3);
    check("restart_respawn", 32'(respawn), 32'd1);
    check("restart_freeze", 32'(freeze), 32'd0);
    check("restart_over", 32'(game_over), 32'd0);
    step();
    step();
    check("restart_nosample", 32'(hit), 32'd0);

    // Reset one cycle after a colliding tick aborts the pending hit
    tick_step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_hit", 32'(hit), 32'd0);
    check("abort_lives", 32'(lives), 32'd3);
    step();
    step();
    check("abort_nohit_later", 32'(hit), 32'd0);

    // Randomized phase against the model
    for (int n = 0; n < 800; n++) begin
      reset   = ($urandom_range(0, 149) == 0);
      restart = ($urandom_range(0, 9) == 0);
      tick    = ($urandom_range(0, 2) == 0);
      if (tick) begin
        px = int'($urandom_range(0, 1023));
        py = int'($urandom_range(0, 1023));
        player_x = W'(px);
        player_y = W'(py);
        for (int g = 0; g < 4; g++) begin
          if ($urandom_range(0, 2) == 0) set_ghost(g, near(px), near(py));
          else set_ghost(g, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end
      end
      step();
    end
    reset = 1'b0;
    restart = 1'b0;
    tick = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
